// File: rtl/wta_k.sv
// rtl/wta_k.sv - clocked k-winner-take-all with gamma timer and fixed-width winner pulses
module wta_k #(
    parameter int NUM_INPUTS      = 16,
    parameter int K               = 1,
    parameter int GAMMA_CYCLE_LEN = 16,
    parameter int PULSE_WIDTH     = 8,
    parameter bit FALLING         = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_INPUTS-1:0]        input_spikes,
    output logic [NUM_INPUTS-1:0]        output_spikes,
    output logic                         gamma_start,
    output logic                         inhibit,
    output logic [$clog2(K+1)-1:0]       win_count
);
    localparam int GW = (GAMMA_CYCLE_LEN > 2) ? $clog2(GAMMA_CYCLE_LEN) : 1;
    localparam int WW = $clog2(K+1);
    localparam int CW = $clog2(PULSE_WIDTH+1);
    localparam logic [NUM_INPUTS-1:0] IDLE = FALLING ? '1 : '0;

    logic [GW-1:0]         g;
    logic [NUM_INPUTS-1:0] in_q, in_q2, fired;
    logic [NUM_INPUTS-1:0] edges, cand, sel, fired_n, out_n;
    logic [CW-1:0]         cnt   [NUM_INPUTS];
    logic [CW-1:0]         cnt_n [NUM_INPUTS];
    logic [WW-1:0]         wc_n;
    logic                  boundary;
    int                    taken, room;

    assign gamma_start = (g == '0);
    assign inhibit     = (win_count == WW'(K));

    always_comb begin
        boundary = (g == GW'(GAMMA_CYCLE_LEN-1));
        edges    = FALLING ? (in_q2 & ~in_q) : (in_q & ~in_q2);
        cand     = edges & ~fired;
        sel      = '0;
        taken    = 0;
        room     = K - int'(win_count);
        // Lowest index wins ties; anything beyond the remaining room is dropped.
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (cand[i] && (taken < room)) begin
                sel[i] = 1'b1;
                taken  = taken + 1;
            end
        end
        if (boundary) begin
            fired_n = '0;
            wc_n    = '0;
        end else begin
            fired_n = fired | sel;
            wc_n    = win_count + WW'(taken);
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (boundary)
                cnt_n[i] = '0;
            else if (sel[i])
                cnt_n[i] = CW'(PULSE_WIDTH);
            else if (cnt[i] != '0)
                cnt_n[i] = cnt[i] - CW'(1);
            else
                cnt_n[i] = cnt[i];
            out_n[i] = (cnt_n[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g             <= '0;
            in_q          <= IDLE;
            in_q2         <= IDLE;
            fired         <= '0;
            win_count     <= '0;
            output_spikes <= '0;
            for (int i = 0; i < NUM_INPUTS; i++)
                cnt[i] <= '0;
        end else begin
            g             <= boundary ? '0 : g + GW'(1);
            in_q          <= input_spikes;
            in_q2         <= in_q;
            fired         <= fired_n;
            win_count     <= wc_n;
            output_spikes <= out_n;
            for (int i = 0; i < NUM_INPUTS; i++)
                cnt[i] <= cnt_n[i];
        end
    end
endmodule

// File: tb/tb_wta_k.sv
// tb/tb_wta_k.sv - scoreboard bench for wta_k, rising and falling polarity instances
module tb_wta_k;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_r, in_f, o_r, o_f;
    logic       gs_r, gs_f, inh_r, inh_f;
    logic [1:0] wc_r, wc_f;

    always #5 clk = ~clk;

    wta_k #(.NUM_INPUTS(8), .K(2), .GAMMA_CYCLE_LEN(16), .PULSE_WIDTH(3), .FALLING(1'b0)) dut_r (
        .clk(clk), .rst(rst), .input_spikes(in_r), .output_spikes(o_r),
        .gamma_start(gs_r), .inhibit(inh_r), .win_count(wc_r));

    wta_k #(.NUM_INPUTS(8), .K(2), .GAMMA_CYCLE_LEN(16), .PULSE_WIDTH(3), .FALLING(1'b1)) dut_f (
        .clk(clk), .rst(rst), .input_spikes(in_f), .output_spikes(o_f),
        .gamma_start(gs_f), .inhibit(inh_f), .win_count(wc_f));

    typedef struct {
        bit         fal;
        logic [7:0] o;
        logic [1:0] w;
        bit         gs;
        int         id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   gcnt  = 0;
    int   sid   = 0;

    task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
        end
    endtask

    // Monitor: one expected record per clock, compared away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                if (mon_e.fal) begin
                    chk("output_spikes_f", mon_e.id, o_f, mon_e.o);
                    chk("win_count_f", mon_e.id, {6'b0, wc_f}, {6'b0, mon_e.w});
                    chk("inhibit_f", mon_e.id, {7'b0, inh_f}, {7'b0, mon_e.w == 2'd2});
                    chk("gamma_start_f", mon_e.id, {7'b0, gs_f}, {7'b0, mon_e.gs});
                end else begin
                    chk("output_spikes", mon_e.id, o_r, mon_e.o);
                    chk("win_count", mon_e.id, {6'b0, wc_r}, {6'b0, mon_e.w});
                    chk("inhibit", mon_e.id, {7'b0, inh_r}, {7'b0, mon_e.w == 2'd2});
                    chk("gamma_start", mon_e.id, {7'b0, gs_r}, {7'b0, mon_e.gs});
                end
            end
        end
    end

    // Drive one clock of stimulus and queue the outputs expected after that edge
    task automatic step(input bit fal, input bit r, input logic [7:0] in,
                        input logic [7:0] eo, input logic [1:0] ew);
        exp_t e;
        @(negedge clk);
        #1;
        rst = r;
        if (fal) begin
            in_f = in;
            in_r = 8'h00;
        end else begin
            in_r = in;
            in_f = 8'hFF;
        end
        gcnt = r ? 0 : (gcnt + 1) % 16;
        e.fal = fal; e.o = eo; e.w = ew; e.gs = (gcnt == 0); e.id = sid;
        sid++;
        sb.push_back(e);
    endtask

    task automatic s(input logic [7:0] in, input logic [7:0] eo, input logic [1:0] ew);
        step(1'b0, 1'b0, in, eo, ew);
    endtask

    task automatic sf(input logic [7:0] in, input logic [7:0] eo, input logic [1:0] ew);
        step(1'b1, 1'b0, in, eo, ew);
    endtask

    task automatic rs(input bit fal, input logic [7:0] in);
        step(fal, 1'b1, in, 8'h00, 2'd0);
    endtask

    initial begin
        rst  = 1'b1;
        in_r = 8'h00;
        in_f = 8'hFF;

        // T1: single winner ch5, then two rises with one slot left
        rs(0, 8'h00);
        s(8'h00, 8'h00, 0); s(8'h00, 8'h00, 0);
        s(8'h20, 8'h00, 0);
        s(8'h20, 8'h20, 1); s(8'h20, 8'h20, 1); s(8'h20, 8'h20, 1);
        s(8'h20, 8'h00, 1);
        s(8'h23, 8'h00, 1);
        s(8'h23, 8'h01, 2); s(8'h23, 8'h01, 2);

        // T2: three-way tie, K saturation, later rise ignored, wrap clears count
        rs(0, 8'h00);
        s(8'h00, 8'h00, 0); s(8'h00, 8'h00, 0); s(8'h00, 8'h00, 0);
        s(8'h4A, 8'h00, 0);
        s(8'h4A, 8'h0A, 2); s(8'h4A, 8'h0A, 2); s(8'h4A, 8'h0A, 2);
        s(8'h4A, 8'h00, 2);
        s(8'hCA, 8'h00, 2);
        repeat (6) s(8'hCA, 8'h00, 2);
        s(8'hCA, 8'h00, 0);
        s(8'hCA, 8'h00, 0);

        // T3: candidate at g=14 truncated, candidate at g=15 discarded
        rs(0, 8'h00);
        repeat (13) s(8'h00, 8'h00, 0);
        s(8'h04, 8'h00, 0);
        s(8'h05, 8'h04, 1);
        s(8'h05, 8'h00, 0);
        s(8'h05, 8'h00, 0);

        // T4: re-fire within a gamma cycle ignored, wins again after wrap
        rs(0, 8'h00);
        s(8'h10, 8'h00, 0);
        s(8'h00, 8'h10, 1); s(8'h10, 8'h10, 1); s(8'h10, 8'h10, 1);
        s(8'h10, 8'h00, 1);
        repeat (10) s(8'h10, 8'h00, 1);
        s(8'h00, 8'h00, 0);
        s(8'h10, 8'h00, 0);
        s(8'h10, 8'h10, 1);

        // T5: falling polarity
        rs(1, 8'hFF);
        sf(8'hFB, 8'h00, 0);
        sf(8'hFB, 8'h04, 1); sf(8'hFB, 8'h04, 1); sf(8'hFB, 8'h04, 1);
        sf(8'hFB, 8'h00, 1);
        sf(8'hFF, 8'h00, 1); sf(8'hFF, 8'h00, 1); sf(8'hFF, 8'h00, 1);

        // T6: reset in the middle of a pulse
        rs(0, 8'h00);
        s(8'h02, 8'h00, 0);
        s(8'h02, 8'h02, 1); s(8'h02, 8'h02, 1);
        rs(0, 8'h00);
        s(8'h00, 8'h00, 0); s(8'h00, 8'h00, 0);
        s(8'h02, 8'h00, 0);
        s(8'h02, 8'h02, 1);

        repeat (2) @(negedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d records left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
